mem_access_ctrl: RTL

//   Memory-side end of the register bank's MC memory-request interface. Accepts MW/MR

---
 rtl/mem_access_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// mem_access_ctrl : MW/MR micro-op to req/ack memory port bridge with timeout
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_access_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        MC,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] WRdata,
  output logic              busy,
  output logic [DATA_W-1:0] Mdata,
  output logic              Mvalid,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] C_LAST_CNT = 8'(WAIT_MAX - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_cnt;
  logic [7:0]        w_cnt_nxt;
  logic              w_busy_nxt;
  logic [DATA_W-1:0] w_mdata_nxt;
  logic              w_mvalid_nxt;
  logic              w_err_nxt;
  logic              w_req_nxt;
  logic              w_we_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_wdata_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      busy      <= 1'b0;
      Mdata     <= '0;
      Mvalid    <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      busy      <= w_busy_nxt;
      Mdata     <= w_mdata_nxt;
      Mvalid    <= w_mvalid_nxt;
      err       <= w_err_nxt;
      mem_req   <= w_req_nxt;
      mem_we    <= w_we_nxt;
      mem_addr  <= w_addr_nxt;
      mem_wdata <= w_wdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_mdata_nxt  = Mdata;
    w_mvalid_nxt = 1'b0;
    w_err_nxt    = 1'b0;
    w_req_nxt    = mem_req;
    w_we_nxt     = mem_we;
    w_addr_nxt   = mem_addr;
    w_wdata_nxt  = mem_wdata;

    case (r_state)
      IDLE: begin
        case (MC)
          2'b01: begin
            w_addr_nxt  = addr;
            w_wdata_nxt = WRdata;
            w_we_nxt    = 1'b1;
            w_req_nxt   = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ACCESS;
          end
          2'b10: begin
            w_addr_nxt  = addr;
            w_we_nxt    = 1'b0;
            w_req_nxt   = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ACCESS;
          end
          2'b11:   w_err_nxt = 1'b1;
          default: ;
        endcase
      end
      ACCESS: begin
        // ack wins over a timeout landing in the same cycle
        if (mem_ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = DONE;
          if (!mem_we) begin
            w_mdata_nxt  = mem_rdata;
            w_mvalid_nxt = 1'b1;
          end
        end else if (r_cnt == C_LAST_CNT) begin
          w_req_nxt   = 1'b0;
          w_err_nxt   = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      DONE: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

endmodule

`default_nettype wire
